// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - debounced three-press operand/opcode loader and result latch for the ALU
// Optional ALU_SEQ_CHAIN_EN: a press in SHOW feeds result[2:0] back as operand A and skips to LOAD_B.
module alu_operand_sequencer #(
  parameter int DB_COUNT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic [1:0] selIn,
  input  logic       btnEnter,
  input  logic [3:0] q,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [1:0] swSelect,
  output logic [3:0] result,
  output logic       resultValid,
  output logic [2:0] stateOut
);

  localparam int CW = $clog2(DB_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'b000,
    LOAD_B  = 3'b001,
    LOAD_OP = 3'b010,
    EXEC    = 3'b011,
    SHOW    = 3'b100
  } state_t;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press;

  state_t        state_q, state_d;
  logic [2:0]    a_q, a_d;
  logic [2:0]    b_q, b_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    result_q, result_d;
  logic          valid_q, valid_d;

  // Any mismatch shorter than DB_COUNT cycles resets the count, so bounces never accumulate.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press = db_q & ~db_dly_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      LOAD_A: if (press) begin
        a_d     = sw;
        state_d = LOAD_B;
      end
      LOAD_B: if (press) begin
        b_d     = sw;
        state_d = LOAD_OP;
      end
      LOAD_OP: if (press) begin
        sel_d   = selIn;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = q;
        valid_d  = 1'b1;
        state_d  = SHOW;
      end
      SHOW: if (press) begin
        valid_d = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        a_d     = result_q[2:0];
        state_d = LOAD_B;
`else
        state_d = LOAD_A;
`endif
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= btnEnter;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign swSelect    = sel_q;
  assign result      = result_q;
  assign resultValid = valid_q;
  assign stateOut    = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - directed bench for alu_operand_sequencer with DB_COUNT=4
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic [1:0] selIn;
  logic       btnEnter;
  logic [3:0] q;
  logic [2:0] a, b;
  logic [1:0] swSelect;
  logic [3:0] result;
  logic       resultValid;
  logic [2:0] stateOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DB_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .selIn(selIn), .btnEnter(btnEnter), .q(q),
    .a(a), .b(b), .swSelect(swSelect), .result(result), .resultValid(resultValid),
    .stateOut(stateOut)
  );

  // Stand-in for the external combinational ALU.
  always_comb begin
    case (swSelect)
      2'd0:    q = {1'b0, a} + {1'b0, b};
      2'd1:    q = {1'b0, a} - {1'b0, b};
      2'd2:    q = {1'b0, a & b};
      default: q = {1'b0, a | b};
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_btn();
    btnEnter = 1'b1;
    tick(10);
    btnEnter = 1'b0;
    tick(10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 8'(a), 8'h0);
    check({tag, "_b"}, 8'(b), 8'h0);
    check({tag, "_sel"}, 8'(swSelect), 8'h0);
    check({tag, "_result"}, 8'(result), 8'h0);
    check({tag, "_valid"}, 8'(resultValid), 8'h0);
    check({tag, "_state"}, 8'(stateOut), 8'h0);
  endtask

  initial begin
    rst_n = 1'b0; sw = 3'b000; selIn = 2'b00; btnEnter = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 3; i++) begin
      btnEnter = 1'b1; tick(3);
      btnEnter = 1'b0; tick(2);
    end
    tick(10);
    check("bounce_state", 8'(stateOut), 8'h0);
    check("bounce_a", 8'(a), 8'h0);

    sw = 3'b110;
    btnEnter = 1'b1;
    tick(6);
    check("latency_edge5_state", 8'(stateOut), 8'h0);
    tick(1);
    check("latency_edge6_state", 8'(stateOut), 8'h1);
    check("latency_a", 8'(a), 8'h6);
    tick(13);
    check("held_one_press", 8'(stateOut), 8'h1);
    btnEnter = 1'b0;
    tick(10);

    sw = 3'b011;
    press_btn();
    check("partial_state", 8'(stateOut), 8'h2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    sw = 3'b101; press_btn();
    sw = 3'b011; press_btn();
    check("seq_a", 8'(a), 8'h5);
    check("seq_b", 8'(b), 8'h3);
    selIn = 2'b01;
    btnEnter = 1'b1;
    tick(6);
    check("op_before_press", 8'(stateOut), 8'h2);
    tick(1);
    check("exec_state", 8'(stateOut), 8'h3);
    check("exec_sel", 8'(swSelect), 8'h1);
    check("exec_valid", 8'(resultValid), 8'h0);
    tick(1);
    check("show_state", 8'(stateOut), 8'h4);
    check("show_valid", 8'(resultValid), 8'h1);
    check("show_result", 8'(result), 8'h2);
    tick(3);
    btnEnter = 1'b0;
    tick(10);

    sw = 3'b111; selIn = 2'b11;
    tick(5);
    check("idle_sw_a", 8'(a), 8'h5);
    check("idle_sw_sel", 8'(swSelect), 8'h1);
    check("idle_sw_result", 8'(result), 8'h2);

    press_btn();
    check("ret_valid", 8'(resultValid), 8'h0);
    check("ret_b", 8'(b), 8'h3);
    check("ret_sel", 8'(swSelect), 8'h1);
    check("ret_result", 8'(result), 8'h2);
`ifdef ALU_SEQ_CHAIN_EN
    check("ret_state", 8'(stateOut), 8'h1);
    check("ret_a", 8'(a), 8'h2);
`else
    check("ret_state", 8'(stateOut), 8'h0);
    check("ret_a", 8'(a), 8'h5);
`endif

    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    sw = 3'b101; press_btn();
    sw = 3'b101; press_btn();
    selIn = 2'b00; press_btn();
    check("seq2_result", 8'(result), 8'hA);
    check("seq2_valid", 8'(resultValid), 8'h1);
    press_btn();
    check("seq2_ret_valid", 8'(resultValid), 8'h0);
    check("seq2_ret_result", 8'(result), 8'hA);
`ifdef ALU_SEQ_CHAIN_EN
    check("chain_a", 8'(a), 8'h2);
    check("chain_state", 8'(stateOut), 8'h1);
`else
    check("nochain_a", 8'(a), 8'h5);
    check("nochain_state", 8'(stateOut), 8'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
